dbg_display_src: RTL and testbench
==================================

# dbg_display_src

Debug-display source stage for the MIPS CPU board build, sitting directly upstream of the 4-digit 7-segment scanner. It selects one of four 32-bit CPU observation words (PC, instruction, ALU result, memory read data) and presents either the low or high 16-bit half as the scanner's hex value. Two debounced push-buttons step through the sources and toggle halves, and a freeze input holds the displayed value. It also generates the scanner's divided scan clock.

## Interface
- DIV_W, 17: scan-clock divider width; scan_clk = clk / 2^DIV_W.
- DB_CNT, 20000: debounce length in clk cycles, minimum 2.

- clk  in  1  system clock; all state updates on its rising edge.
- clr_n  in  1  reset; synchronous, active-low.
- pc  in  32  current program counter.
- instr  in  32  current instruction word.
- alu_out  in  32  ALU result.
- mem_rdata  in  32  data-memory read data.
- btn_mode  in  1  raw (asynchronous, bouncy) source-step button, active-high.
- btn_half  in  1  raw half-toggle button, active-high.
- freeze  in  1  level; 1 = hold x.
- x  out  16  hex value to the scanner, registered.
- scan_clk  out  1  divided clock for the scanner digit counter, equal to div counter MSB.
- mode  out  2  current source: 0 = pc, 1 = instr, 2 = alu_out, 3 = mem_rdata.
- half  out  1  0 = bits [15:0], 1 = bits [31:16].

## Operation
- Reset (clr_n = 0 at a rising edge): x = 0, mode = 0, half = 0, scan_clk = 0, divider = 0, all synchronizer/debounce state = 0. Applies mid-debounce and mid-freeze; any pending press is discarded.
- Divider: DIV_W-bit free-running up-counter, wraps 2^DIV_W-1 -> 0; scan_clk = bit DIV_W-1, giving a 50% duty cycle.
- Per button, debounce:
  - 2-flop synchronizer produces btn_sync.
  - db_level register, initially 0.
  - Counter cnt:
    - While btn_sync == db_level, cnt <= 0.
    - While btn_sync != db_level and cnt < DB_CNT-1, cnt <= cnt+1.
    - When btn_sync != db_level and cnt == DB_CNT-1, db_level <= btn_sync and cnt <= 0.
  - Any disagreement shorter than DB_CNT cycles is ignored.
- Edge detect: rise = db_level & ~db_prev, where db_prev is db_level delayed one cycle.
  - On btn_mode rise: mode <= mode+1, wrapping 3 -> 0.
  - On btn_half rise: half <= ~half.
  - Release (falling db_level) has no effect.
- Both buttons rising in the same cycle: both updates take effect in that cycle.
- Source word: w = {pc, instr, alu_out, mem_rdata}[mode]; s = half ? w[31:16] : w[15:0].
- x register:
  - freeze = 0: x <= s every cycle.
  - freeze = 1: x holds. mode and half still update and are visible on their outputs.
  - When freeze returns to 0, x <= s at the next edge.

## Timing
- x latency: one cycle from any change in the selected source input, mode, or half, with freeze = 0.
- Button press, with the raw input held high from edge 1:
  - btn_sync = 1 after edge 2.
  - db_level = 1 at edge DB_CNT+2.
  - mode/half updates at edge DB_CNT+3.
  - x reflects the new selection at edge DB_CNT+4.
- Exactly one mode/half step per press regardless of hold duration; the next step requires a debounced release (DB_CNT stable-low cycles) followed by a new press.
- scan_clk period: exactly 2^DIV_W clk cycles; first rising edge at edge 2^(DIV_W-1) after reset release.
- No handshake: x is a continuously valid level and may change on any clk edge.

## Test plan
Bench parameters: DIV_W = 3, DB_CNT = 4.

- **Reset and default source:** pc = 32'h0040_1234, reset 2 cycles then release.
  - Before the first post-reset edge: x = 0, mode = 0, half = 0, scan_clk = 0.
  - After one edge: x = 16'h1234.
- **Mode step and wrap:** btn_mode high for 10 cycles.
  - mode = 1 at edge 7.
  - x = instr[15:0] at edge 8.
  - After four clean presses, mode wraps to 0 and x = 16'h1234.
- **Bounce rejection:** btn_mode toggled 1,0,1,0 on successive cycles, then 0 for 20 cycles.
  - mode unchanged and x unchanged throughout.
- **Half toggle plus simultaneous press:** pc = 32'h0040_1234; both buttons rise together.
  - At the same edge: mode = 1, half = 1.
  - Next edge: x = instr[31:16].
- **Freeze:** freeze = 1, then change pc and press btn_mode.
  - x holds its value while mode still increments.
  - Deassert freeze: x = new selection one cycle later.
- **Divider and reset mid-debounce:**
  - scan_clk toggles every 4 clk cycles.
  - Assert clr_n = 0 during the cnt = 2 window of a press, then release with the button held.
  - Full DB_CNT+3 latency restarts from reset release, and mode = 0 before the step.

Source files
------------

// File: rtl/dbg_display_src.sv
// rtl/dbg_display_src.sv - debug-display source select, button debounce and scan-clock divider
// Picks a 16-bit half of one CPU observation word for the 7-segment scanner.
module dbg_display_src #(
  parameter int DIV_W  = 17,
  parameter int DB_CNT = 20000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_rdata,
  input  logic        btn_mode,
  input  logic        btn_half,
  input  logic        freeze,
  output logic [15:0] x,
  output logic        scan_clk,
  output logic [1:0]  mode,
  output logic        half
);

  localparam int CNT_W = $clog2(DB_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db_level;
  logic [1:0]       db_prev;
  logic [1:0]       rise;
  logic [CNT_W-1:0] cnt [2];
  logic [31:0]      w;
  logic [15:0]      s;

  // bit 0 steps the source, bit 1 toggles the half
  assign raw      = {btn_half, btn_mode};
  assign rise     = db_level & ~db_prev;
  assign scan_clk = div[DIV_W-1];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int b = 0; b < 2; b++) cnt[b] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db_level;
      // level only follows the synced input after DB_CNT consecutive disagreeing cycles
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == db_level[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_MAX) begin
          db_level[b] <= sync2[b];
          cnt[b]      <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w = pc;
    case (mode)
      2'd0: w = pc;
      2'd1: w = instr;
      2'd2: w = alu_out;
      2'd3: w = mem_rdata;
      default: w = pc;
    endcase
    s = half ? w[31:16] : w[15:0];
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      div  <= '0;
      mode <= 2'd0;
      half <= 1'b0;
      x    <= 16'h0000;
    end else begin
      div <= div + 1'b1;
      if (rise[0]) mode <= mode + 2'd1;
      if (rise[1]) half <= ~half;
      if (!freeze) x <= s;
    end
  end

endmodule

// File: tb/tb_dbg_display_src.sv
// tb/tb_dbg_display_src.sv - self-checking bench for dbg_display_src
// Reference model tracks raw-button run lengths and edge counts; directed literals pin it.
module tb_dbg_display_src;

  localparam int DIV_W  = 3;
  localparam int DB_CNT = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] pc, instr, alu_out, mem_rdata;
  logic        btn_mode, btn_half, freeze;
  logic [15:0] x;
  logic        scan_clk;
  logic [1:0]  mode;
  logic        half;

  int tests = 0;
  int fails = 0;

  dbg_display_src #(.DIV_W(DIV_W), .DB_CNT(DB_CNT)) dut (
    .clk(clk), .clr_n(clr_n), .pc(pc), .instr(instr), .alu_out(alu_out),
    .mem_rdata(mem_rdata), .btn_mode(btn_mode), .btn_half(btn_half),
    .freeze(freeze), .x(x), .scan_clk(scan_clk), .mode(mode), .half(half)
  );

  always #5 clk = ~clk;

  // model state
  bit        m_valid = 0;
  int        m_n;
  int        m_mode;
  bit        m_half;
  bit [15:0] m_x;
  bit        m_level [2];
  int        m_run   [2];
  bit        m_dly   [2][2];
  bit        m_rise  [2];

  function automatic bit [15:0] pick(int md, bit hf);
    bit [31:0] wd;
    wd = (md == 0) ? pc : (md == 1) ? instr : (md == 2) ? alu_out : mem_rdata;
    return hf ? wd[31:16] : wd[15:0];
  endfunction

  always @(posedge clk) begin
    bit rawv [2];
    bit seen;
    bit nl;
    rawv[0] = btn_mode;
    rawv[1] = btn_half;
    if (!clr_n) begin
      m_valid = 1;
      m_n = 0; m_mode = 0; m_half = 0; m_x = 0;
      for (int b = 0; b < 2; b++) begin
        m_level[b] = 0; m_run[b] = 0; m_rise[b] = 0;
        m_dly[b][0] = 0; m_dly[b][1] = 0;
      end
    end else begin
      if (!freeze) m_x = pick(m_mode, m_half);
      if (m_rise[0]) m_mode = (m_mode + 1) % 4;
      if (m_rise[1]) m_half = !m_half;
      for (int b = 0; b < 2; b++) begin
        seen = m_dly[b][1];
        nl = m_level[b];
        if (seen == m_level[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DB_CNT) begin nl = seen; m_run[b] = 0; end
        end
        m_rise[b] = nl && !m_level[b];
        m_level[b] = nl;
        m_dly[b][1] = m_dly[b][0];
        m_dly[b][0] = rawv[b];
      end
      m_n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_x", {16'h0, x}, {16'h0, m_x});
      chk("model_mode", {30'h0, mode}, m_mode);
      chk("model_half", {31'h0, half}, {31'h0, m_half});
      chk("model_scan", {31'h0, scan_clk}, ((m_n >> (DIV_W - 1)) & 1));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode;
    btn_mode = 1'b1; step(10);
    btn_mode = 1'b0; step(8);
  endtask

  initial begin
    clr_n = 1'b0; btn_mode = 1'b0; btn_half = 1'b0; freeze = 1'b0;
    pc = 32'h0040_1234; instr = 32'hABCD_5678;
    alu_out = 32'h1111_2222; mem_rdata = 32'h3333_4444;
    step(2);
    clr_n = 1'b1;
    chk("rst_x", {16'h0, x}, 32'h0);
    chk("rst_mode", {30'h0, mode}, 32'h0);
    chk("rst_half", {31'h0, half}, 32'h0);
    chk("rst_scan", {31'h0, scan_clk}, 32'h0);
    step(1);
    chk("first_x", {16'h0, x}, 32'h1234);

    // mode step, then wrap after four presses
    btn_mode = 1'b1;
    step(6);
    chk("mode_e6", {30'h0, mode}, 32'h0);
    step(1);
    chk("mode_e7", {30'h0, mode}, 32'h1);
    chk("x_e7", {16'h0, x}, 32'h1234);
    step(1);
    chk("x_e8", {16'h0, x}, 32'h5678);
    step(2);
    btn_mode = 1'b0;
    step(8);
    for (int i = 0; i < 3; i++) press_mode();
    chk("wrap_mode", {30'h0, mode}, 32'h0);
    chk("wrap_x", {16'h0, x}, 32'h1234);

    // bounce shorter than DB_CNT
    btn_mode = 1'b1; step(1);
    btn_mode = 1'b0; step(1);
    btn_mode = 1'b1; step(1);
    btn_mode = 1'b0; step(20);
    chk("bounce_mode", {30'h0, mode}, 32'h0);
    chk("bounce_x", {16'h0, x}, 32'h1234);

    // simultaneous press
    btn_mode = 1'b1; btn_half = 1'b1;
    step(7);
    chk("both_mode", {30'h0, mode}, 32'h1);
    chk("both_half", {31'h0, half}, 32'h1);
    step(1);
    chk("both_x", {16'h0, x}, 32'hABCD);
    btn_mode = 1'b0; btn_half = 1'b0;
    step(8);

    // freeze holds x while mode advances
    freeze = 1'b1;
    step(1);
    pc = 32'h0040_5678;
    btn_mode = 1'b1;
    step(7);
    chk("frz_mode", {30'h0, mode}, 32'h2);
    chk("frz_x", {16'h0, x}, 32'hABCD);
    step(3);
    btn_mode = 1'b0;
    step(8);
    chk("frz_hold_x", {16'h0, x}, 32'hABCD);
    freeze = 1'b0;
    step(1);
    chk("unfrz_x", {16'h0, x}, 32'h1111);

    // reset in the cnt = 2 window, button kept high through release
    btn_mode = 1'b1;
    step(4);
    clr_n = 1'b0;
    step(1);
    clr_n = 1'b1;
    chk("mid_rst_mode", {30'h0, mode}, 32'h0);
    chk("mid_rst_half", {31'h0, half}, 32'h0);
    chk("mid_rst_x", {16'h0, x}, 32'h0);
    chk("mid_rst_scan", {31'h0, scan_clk}, 32'h0);
    step(3);
    chk("scan_e3", {31'h0, scan_clk}, 32'h0);
    step(1);
    chk("scan_e4", {31'h0, scan_clk}, 32'h1);
    step(2);
    chk("mid_mode_e6", {30'h0, mode}, 32'h0);
    step(1);
    chk("mid_mode_e7", {30'h0, mode}, 32'h1);
    chk("scan_e7", {31'h0, scan_clk}, 32'h1);
    step(1);
    chk("scan_e8", {31'h0, scan_clk}, 32'h0);
    chk("mid_x_e8", {16'h0, x}, 32'h5678);
    btn_mode = 1'b0;
    step(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
